// File: rtl/rvd_downsizer_if.sv
// Wide-to-narrow stream bundle: word input side (s_port_*) and beat output side (m_port_*).
// m_port_last is present only when RVD_DOWNSIZER_LAST_EN is defined.
interface rvd_downsizer_if #(
    parameter int T = 64,
    parameter int W = 16
);
    logic [T-1:0] s_port_data;
    logic         s_port_valid;
    logic         s_port_ready;
    logic [W-1:0] m_port_data;
    logic         m_port_valid;
    logic         m_port_ready;
`ifdef RVD_DOWNSIZER_LAST_EN
    logic         m_port_last;
`endif

`ifdef RVD_DOWNSIZER_LAST_EN
    modport slave (
        input  s_port_data, s_port_valid, m_port_ready,
        output s_port_ready, m_port_data, m_port_valid, m_port_last
    );
    modport master (
        output s_port_data, s_port_valid, m_port_ready,
        input  s_port_ready, m_port_data, m_port_valid, m_port_last
    );
`else
    modport slave (
        input  s_port_data, s_port_valid, m_port_ready,
        output s_port_ready, m_port_data, m_port_valid
    );
    modport master (
        output s_port_data, s_port_valid, m_port_ready,
        input  s_port_ready, m_port_data, m_port_valid
    );
`endif
endinterface

// File: rtl/rvd_downsizer.sv
// Splits each T-bit input word into N = T/W output beats, LSB first, at one beat per cycle.
// Optional feature macro RVD_DOWNSIZER_LAST_EN adds m_port_last on the final beat of each word.
module rvd_downsizer #(
    parameter int T = 64,
    parameter int W = 16
) (
    input logic           clk,
    input logic           reset,
    rvd_downsizer_if.slave bus
);
    localparam int N  = T / W;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

    typedef enum logic {
        EMPTY,
        BUSY
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [T-1:0]  hold_q;
    logic [T-1:0]  hold_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          at_last;
    logic          in_hs;
    logic          out_hs;

    // Outputs are forced low while reset is held, even before the register has been cleared.
    assign at_last          = (state_q == BUSY) && (cnt_q == LAST_CNT);
    assign bus.m_port_valid = !reset && (state_q == BUSY);
    assign bus.s_port_ready = !reset && ((state_q == EMPTY) || (at_last && bus.m_port_ready));
    assign bus.m_port_data  = hold_q[int'(cnt_q) * W +: W];
`ifdef RVD_DOWNSIZER_LAST_EN
    assign bus.m_port_last  = !reset && at_last;
`endif

    assign in_hs  = bus.s_port_valid && bus.s_port_ready;
    assign out_hs = bus.m_port_valid && bus.m_port_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
            hold_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            cnt_q   <= cnt_d;
        end
    end

    // On the last beat a waiting word is loaded in the same cycle, so back-to-back words never bubble.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        cnt_d   = cnt_q;
        case (state_q)
            EMPTY: begin
                if (in_hs) begin
                    hold_d  = bus.s_port_data;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (out_hs) begin
                    if (cnt_q != LAST_CNT) begin
                        cnt_d = cnt_q + 1'b1;
                    end else if (in_hs) begin
                        hold_d = bus.s_port_data;
                        cnt_d  = '0;
                    end else begin
                        cnt_d   = '0;
                        state_d = EMPTY;
                    end
                end
            end
            default: begin
                state_d = EMPTY;
                cnt_d   = '0;
            end
        endcase
    end
endmodule

// File: tb/tb_rvd_downsizer.sv
// Randomized scoreboard bench for rvd_downsizer (T=64, W=16): every accepted word is split into
// its expected beats and a monitor pops and compares each delivered beat.
module tb_rvd_downsizer;
    localparam int T = 64;
    localparam int W = 16;
    localparam int N = T / W;

    typedef struct {
        logic [W-1:0] data;
        logic         last;
    } beat_t;

    logic  clk;
    logic  reset;
    int    checks;
    int    failures;
    logic  rand_mode;
    logic  m_ready_cmd;
    beat_t exp_q[$];

    rvd_downsizer_if #(.T(T), .W(W)) bus ();

    rvd_downsizer #(.T(T), .W(W)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one word, optionally preceded by random idle cycles carrying junk data.
    task automatic applyStimulus(input logic [T-1:0] word, input bit gaps);
        bit accepted;
        if (gaps) begin
            while ($urandom_range(0, 1) == 1) begin
                bus.s_port_valid = 1'b0;
                bus.s_port_data  = {$urandom, $urandom};
                step();
            end
        end
        bus.s_port_valid = 1'b1;
        bus.s_port_data  = word;
        accepted = 1'b0;
        for (int c = 0; c < 500 && !accepted; c++) begin
            @(negedge clk);
            if (bus.s_port_ready) accepted = 1'b1;
            step();
        end
        bus.s_port_valid = 1'b0;
        bus.s_port_data  = {$urandom, $urandom};
        if (!accepted) begin
            checks++;
            failures++;
            $display("[TB] FAIL accept_timeout actual=not_accepted expected=accepted at %0t", $time);
        end
    endtask

    // Downstream ready: either random or directed by the main sequence.
    initial begin
        bus.m_port_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            bus.m_port_ready = rand_mode ? 1'($urandom_range(0, 1)) : m_ready_cmd;
        end
    end

    // Scoreboard monitor: reference split is plain shifting of the accepted word.
    initial begin
        beat_t e;
        beat_t b;
        logic [T-1:0] w;
        forever begin
            @(negedge clk);
            if (reset) begin
                checkOutput("reset_m_valid", 64'(bus.m_port_valid), 64'd0);
                checkOutput("reset_s_ready", 64'(bus.s_port_ready), 64'd0);
`ifdef RVD_DOWNSIZER_LAST_EN
                checkOutput("reset_m_last", 64'(bus.m_port_last), 64'd0);
`endif
                exp_q.delete();
            end else begin
                if (bus.m_port_valid && bus.m_port_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("[TB] FAIL unexpected_beat actual=%0h expected=none at %0t", bus.m_port_data, $time);
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("beat_data", 64'(bus.m_port_data), 64'(e.data));
`ifdef RVD_DOWNSIZER_LAST_EN
                        checkOutput("beat_last", 64'(bus.m_port_last), 64'(e.last));
`endif
                    end
                end
                if (bus.s_port_valid && bus.s_port_ready) begin
                    w = bus.s_port_data;
                    for (int i = 0; i < N; i++) begin
                        b.data = W'(w >> (W * i));
                        b.last = (i == N - 1);
                        exp_q.push_back(b);
                    end
                end
            end
        end
    end

    initial begin
        logic [T-1:0] w;
        checks      = 0;
        failures    = 0;
        rand_mode   = 1'b0;
        m_ready_cmd = 1'b1;
        reset       = 1'b1;
        bus.s_port_valid = 1'b0;
        bus.s_port_data  = '0;
        repeat (3) step();
        reset = 1'b0;
        @(negedge clk);
        checkOutput("post_reset_s_ready", 64'(bus.s_port_ready), 64'd1);
        checkOutput("post_reset_m_valid", 64'(bus.m_port_valid), 64'd0);

        // Single word: four consecutive beats, LSB first, then idle.
        step();
        w = 64'h4444_3333_2222_1111;
        applyStimulus(w, 1'b0);
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            checkOutput("single_valid", 64'(bus.m_port_valid), 64'd1);
            checkOutput("single_data", 64'(bus.m_port_data), (w >> (W * i)) & 64'hFFFF);
`ifdef RVD_DOWNSIZER_LAST_EN
            checkOutput("single_last", 64'(bus.m_port_last), (i == N - 1) ? 64'd1 : 64'd0);
`endif
        end
        @(negedge clk);
        checkOutput("single_idle_valid", 64'(bus.m_port_valid), 64'd0);

        // Back-to-back words: 32 beats with no bubble, ready only on each final beat.
        step();
        fork
            begin
                for (int k = 0; k < 8; k++) applyStimulus({$urandom, $urandom}, 1'b0);
            end
            begin
                @(posedge clk);
                for (int k = 0; k < 32; k++) begin
                    @(negedge clk);
                    checkOutput("b2b_valid", 64'(bus.m_port_valid), 64'd1);
                    checkOutput("b2b_s_ready", 64'(bus.s_port_ready), (k % N == N - 1) ? 64'd1 : 64'd0);
                end
            end
        join
        repeat (6) step();

        // Backpressure on the third beat.
        w = 64'h4444_3333_2222_1111;
        applyStimulus(w, 1'b0);
        step();
        step();
        m_ready_cmd = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("stall_valid", 64'(bus.m_port_valid), 64'd1);
            checkOutput("stall_data", 64'(bus.m_port_data), 64'h3333);
            checkOutput("stall_s_ready", 64'(bus.s_port_ready), 64'd0);
            step();
        end
        m_ready_cmd = 1'b1;
        repeat (6) step();

        // Reset after the first beat of a word discards the rest.
        applyStimulus(64'h1234_5678_9ABC_DEF0, 1'b0);
        step();
        reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("post_midreset_m_valid", 64'(bus.m_port_valid), 64'd0);
            if (i == 0) checkOutput("post_midreset_s_ready", 64'(bus.s_port_ready), 64'd1);
            step();
        end
        applyStimulus(64'hAAAA_BBBB_CCCC_DDDD, 1'b0);
        @(negedge clk);
        checkOutput("after_reset_valid", 64'(bus.m_port_valid), 64'd1);
        checkOutput("after_reset_first", 64'(bus.m_port_data), 64'hDDDD);
        repeat (6) step();

        // Random valid/ready traffic.
        rand_mode = 1'b1;
        for (int k = 0; k < 1000; k++) applyStimulus({$urandom, $urandom}, 1'b1);
        rand_mode   = 1'b0;
        m_ready_cmd = 1'b1;
        for (int c = 0; c < 200 && exp_q.size() != 0; c++) step();
        repeat (2) step();
        checkOutput("drain_empty", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
